// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer driven by an sclk-synchronous baud
// square wave. A one-entry holding register feeds the shift register so
// frames go out back-to-back. Frame: start, DATA_W data bits (LSB first),
// optional parity, STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (even when PARITY_ODD=0, odd when PARITY_ODD=1).
//
// Handshake: a byte transfers on the sclk edge where tx_valid_i and
// tx_ready_o are both high; tx_ready_o is the inverse of the registered
// hold_full flag, so it never re-asserts in the cycle of an accept.
module uart_tx_frame #(
    parameter int DATA_W     = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              baud_clk_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic              txd_o,
    output logic              busy_o,
    output logic [2:0]        dbg_state
);

    // Elaboration-time guards on the legal parameter ranges.
    if (DATA_W < 5 || DATA_W > 8) begin : g_bad_data_w
        $error("uart_tx_frame: DATA_W must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_t              state, state_n;
    logic                baud_q;
    logic                tick;
    logic [DATA_W-1:0]   hold, hold_n;
    logic                hold_full, hold_full_n;
    logic [DATA_W-1:0]   shift, shift_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic                stop_cnt, stop_cnt_n;
    logic                txd_q, txd_n;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_n;
`endif

    // Rising edge of the baud wave marks one bit period; no synchroniser
    // since the generator runs on sclk.
    assign tick = baud_clk_i & ~baud_q;

    // State and datapath registers; reset forces the line idle high at once.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            baud_q    <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            baud_q    <= baud_clk_i;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            stop_cnt  <= stop_cnt_n;
            txd_q     <= txd_n;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_n;
`endif
        end
    end

    // Next-state and datapath logic; every FSM move is gated by tick.
    always_comb begin
        state_n     = state;
        hold_n      = hold;
        hold_full_n = hold_full;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        stop_cnt_n  = stop_cnt;
        txd_n       = txd_q;
`ifdef UART_TX_PARITY_EN
        par_n       = par_q;
`endif

        // Accept into the holding register. Only possible while hold is
        // empty, so it never collides with the hold->shift load below.
        if (tx_valid_i && !hold_full) begin
            hold_n      = tx_data_i;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (tick && hold_full) begin
                    shift_n     = hold;
                    hold_full_n = 1'b0;
                    txd_n       = 1'b0;
                    state_n     = START;
`ifdef UART_TX_PARITY_EN
                    par_n       = (^hold) ^ 1'(PARITY_ODD);
`endif
                end
            end

            START: begin
                if (tick) begin
                    txd_n     = shift[0];
                    bit_cnt_n = 3'd0;
                    state_n   = DATA;
                end
            end

            DATA: begin
                if (tick) begin
                    shift_n = {1'b0, shift[DATA_W-1:1]};
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        txd_n   = par_q;
                        state_n = PARITY;
`else
                        txd_n      = 1'b1;
                        stop_cnt_n = 1'b0;
                        state_n    = STOP;
`endif
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        txd_n     = shift[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    txd_n      = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = STOP;
                end
            end
`endif

            STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        if (hold_full) begin
                            // Next byte is already waiting: start bit follows
                            // the last stop bit with no idle period.
                            shift_n     = hold;
                            hold_full_n = 1'b0;
                            txd_n       = 1'b0;
                            state_n     = START;
`ifdef UART_TX_PARITY_EN
                            par_n       = (^hold) ^ 1'(PARITY_ODD);
`endif
                        end else begin
                            txd_n   = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end

            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    assign tx_ready_o = ~hold_full;
    assign busy_o     = (state != IDLE) | hold_full;
    assign txd_o      = txd_q;
    assign dbg_state  = state;

endmodule
